fb_frame_scheduler: RTL

Owns the single framebuffer write port and sequences each frame as IDLE -> CLEAR -> DRAW -> IDLE, triggered by the scanout frame-start pulse. In CLEAR, a built-in clear engine writes zeros to the whole buffer, one address per gated cycle. In DRAW, plot requests from the curve generator pass through a valid/ready handshake to the port. The block also reports phase, frame completion and overruns to the control logic.

---
 rtl/fb_frame_scheduler_pkg.sv | 15 +
 rtl/fb_clear_engine.sv | 32 +++
 rtl/fb_frame_scheduler.sv | 99 +++++++++
 3 files changed

// File: rtl/fb_frame_scheduler_pkg.sv
// Shared framebuffer definitions: phase encodings and default geometry,
// common to scanout, plot generator and frame scheduler.
package fb_frame_scheduler_pkg;

  localparam int unsigned FB_DEPTH_DEFAULT = 307200;  // 640x480
  localparam int unsigned ADDR_W_DEFAULT   = 19;
  localparam int unsigned DATA_W_DEFAULT   = 8;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_CLEAR = 2'd1,
    PH_DRAW  = 2'd2
  } phase_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Gated clear address counter: advances one address per step and wraps to 0
// after the final framebuffer entry.
module fb_clear_engine
  import fb_frame_scheduler_pkg::*;
#(
  parameter int unsigned FB_DEPTH = FB_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  logic [ADDR_W-1:0] ptr;

  assign addr = ptr;
  assign last = (ptr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      ptr <= '0;
    end else if (step) begin
      ptr <= last ? '0 : ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fb_frame_scheduler.sv
// Framebuffer write-port owner: sequences IDLE -> CLEAR -> DRAW per frame and
// muxes the clear engine or plot requests onto a registered write port.
module fb_frame_scheduler
  import fb_frame_scheduler_pkg::*;
#(
  parameter int unsigned FB_DEPTH = FB_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              clear_gate,
  input  logic              trails_en,
  input  logic              plot_valid,
  input  logic [ADDR_W-1:0] plot_addr,
  input  logic [DATA_W-1:0] plot_data,
  input  logic              plot_inrange,
  input  logic              plot_last,
  output logic              plot_ready,
  output logic              draw_start,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic [1:0]        phase,
  output logic              frame_done,
  output logic              overrun,
  output logic [7:0]        overrun_count
);

  phase_t            state, state_next;
  logic              clr_load, clr_step, clr_last;
  logic [ADDR_W-1:0] clr_addr;
  logic              plot_hs;

  assign plot_ready = (state == PH_DRAW);
  assign plot_hs    = plot_valid && plot_ready;
  assign phase      = state;
  assign clr_load   = (state == PH_IDLE) && frame_start && !trails_en;
  assign clr_step   = (state == PH_CLEAR) && clear_gate;

  fb_clear_engine #(
    .FB_DEPTH (FB_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_clear (
    .clk   (clk),
    .reset (reset),
    .load  (clr_load),
    .step  (clr_step),
    .addr  (clr_addr),
    .last  (clr_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= PH_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      PH_IDLE:  if (frame_start) state_next = trails_en ? PH_DRAW : PH_CLEAR;
      PH_CLEAR: if (clr_step && clr_last) state_next = PH_DRAW;
      PH_DRAW:  if (plot_hs && plot_last) state_next = PH_IDLE;
      default:  state_next = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we         <= 1'b0;
      fb_waddr      <= '0;
      fb_wdata      <= '0;
      draw_start    <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      fb_we      <= 1'b0;
      draw_start <= (state != PH_DRAW) && (state_next == PH_DRAW);
      frame_done <= plot_hs && plot_last;
      if (clr_step) begin
        fb_we    <= 1'b1;
        fb_waddr <= clr_addr;
        fb_wdata <= '0;
      end else if (plot_hs) begin
        fb_we    <= plot_inrange;
        fb_waddr <= plot_addr;
        fb_wdata <= plot_data;
      end
      // A frame_start outside IDLE never restarts the frame; it is only logged.
      if (frame_start && state != PH_IDLE) begin
        overrun <= 1'b1;
        if (overrun_count != '1) overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule
